booth_mult_seq: RTL and testbench

//  Parametrised radix-2 Booth sequential multiplier: control FSM, iteration counter and datapath in one block.

---
 rtl/booth_mult_seq.sv | 138 +++++++++++++
 tb/tb_booth_mult_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module   : booth_mult_seq
//  Purpose  : Radix-2 Booth sequential signed multiplier. Control FSM,
//             iteration counter and add/shift datapath in one block.
//             One Booth step (add/sub + arithmetic shift) per clock,
//             start/ready handshake, valid held until the next start.
//  Revision : 1.0 - initial release
// ============================================================================
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 ready,
    output logic                 busy,
    output logic                 valid,
    output logic [2*WIDTH-1:0]   product,
    output logic                 op_sub,
    output logic                 op_add
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    // A and M carry one extra sign bit so that subtracting M = -2^(WIDTH-1)
    // can never overflow the accumulator.
    logic [WIDTH:0]       r_a;
    logic [WIDTH-1:0]     r_q;
    logic                 r_q1;
    logic [WIDTH:0]       r_m;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_load;
    logic                 w_step;
    logic [WIDTH:0]       w_sum;
    logic [1:0]           w_pair;

    assign w_pair  = {r_q[0], r_q1};
    assign product = {r_a[WIDTH-1:0], r_q};

    // Booth add/subtract selected by the current {Q[0], q_1} pair
    always_comb begin
        w_sum = r_a;
        case (w_pair)
            2'b01:   w_sum = r_a + r_m;
            2'b10:   w_sum = r_a - r_m;
            default: w_sum = r_a;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode, handshake outputs and datapath controls
    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        busy        = 1'b0;
        valid       = 1'b0;
        w_load      = 1'b0;
        w_step      = 1'b0;
        op_add      = 1'b0;
        op_sub      = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                busy   = 1'b1;
                w_step = 1'b1;
                op_add = (w_pair == 2'b01);
                op_sub = (w_pair == 2'b10);
                // The step that takes the counter from 1 to 0 is the last one
                if (r_count == c_CNT_W'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                ready = 1'b1;
                valid = 1'b1;
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_CALC;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand load on an accepted start, otherwise one Booth step per CALC cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_q     <= '0;
            r_q1    <= 1'b0;
            r_m     <= '0;
            r_count <= '0;
        end else if (w_load) begin
            r_a     <= '0;
            r_q     <= multiplier;
            r_q1    <= 1'b0;
            r_m     <= {multiplicand[WIDTH-1], multiplicand};
            r_count <= c_CNT_W'(WIDTH);
        end else if (w_step) begin
            // Arithmetic right shift of {A, Q, q_1} applied to the new A
            r_a     <= {w_sum[WIDTH], w_sum[WIDTH:1]};
            r_q     <= {w_sum[0], r_q[WIDTH-1:1]};
            r_q1    <= r_q[0];
            r_count <= r_count - c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_booth_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_booth_mult_seq
//  Purpose  : Self-checking directed bench for booth_mult_seq, with an
//             8-bit and a 4-bit instance sharing clock and reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_booth_mult_seq;

    logic        clk = 1'b0;
    logic        rst;

    logic        start8;
    logic [7:0]  mc8, mq8;
    logic        ready8, busy8, valid8, op_sub8, op_add8;
    logic [15:0] product8;

    logic        start4;
    logic [3:0]  mc4, mq4;
    logic        ready4, busy4, valid4, op_sub4, op_add4;
    logic [7:0]  product4;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] n_add, n_sub;
    logic        op_both = 1'b0;
    logic [7:0]  e4;

    always #5 clk = ~clk;

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8),
        .multiplicand(mc8), .multiplier(mq8),
        .ready(ready8), .busy(busy8), .valid(valid8),
        .product(product8), .op_sub(op_sub8), .op_add(op_add8)
    );

    booth_mult_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .multiplicand(mc4), .multiplier(mq4),
        .ready(ready4), .busy(busy4), .valid(valid4),
        .product(product4), .op_sub(op_sub4), .op_add(op_add4)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sample_ops8();
        if (op_add8) n_add = n_add + 16'd1;
        if (op_sub8) n_sub = n_sub + 16'd1;
        if (op_add8 && op_sub8) op_both = 1'b1;
    endtask

    // Full 8-bit transaction: accept, 8 busy cycles, valid after edge k+8
    task automatic run8(input logic [7:0] m, input logic [7:0] q,
                        input logic [15:0] exp, input string tag);
        start8 = 1'b1; mc8 = m; mq8 = q;
        n_add = 16'd0; n_sub = 16'd0;
        @(posedge clk); #1;
        start8 = 1'b0; mc8 = 8'($urandom); mq8 = 8'($urandom);
        chk1({tag, "_busy_first"}, busy8, 1'b1);
        sample_ops8();
        repeat (7) begin
            @(posedge clk); #1;
            sample_ops8();
        end
        chk1({tag, "_busy_last"}, busy8, 1'b1);
        chk1({tag, "_valid_early"}, valid8, 1'b0);
        @(posedge clk); #1;
        chk1({tag, "_valid"}, valid8, 1'b1);
        chk1({tag, "_ready"}, ready8, 1'b1);
        chk16({tag, "_product"}, product8, exp);
    endtask

    // Full 4-bit transaction: valid after edge k+4
    task automatic run4(input logic [3:0] m, input logic [3:0] q,
                        input logic [7:0] exp, input string tag);
        start4 = 1'b1; mc4 = m; mq4 = q;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk1({tag, "_valid_early"}, valid4, 1'b0);
        @(posedge clk); #1;
        chk1({tag, "_valid"}, valid4, 1'b1);
        chk16({tag, "_product"}, {8'h00, product4}, {8'h00, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start8 = 1'b0; mc8 = 8'd0; mq8 = 8'd0;
        start4 = 1'b0; mc4 = 4'd0; mq4 = 4'd0;
        #3;
        chk1("rst_ready", ready8, 1'b1);
        chk1("rst_busy", busy8, 1'b0);
        chk1("rst_valid", valid8, 1'b0);
        chk16("rst_product", product8, 16'h0000);
        chk1("rst_op_add", op_add8, 1'b0);
        chk1("rst_op_sub", op_sub8, 1'b0);
        chk1("rst_ready4", ready4, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic products and Booth operation counts
        run8(8'd3, 8'd5, 16'h000F, "m3_q5");
        chk16("m3_q5_n_sub", n_sub, 16'd2);
        chk16("m3_q5_n_add", n_add, 16'd2);
        // product held stable while valid
        @(posedge clk); #1;
        chk1("hold_valid", valid8, 1'b1);
        chk16("hold_product", product8, 16'h000F);

        run8(8'hF9, 8'd3,  16'hFFEB, "m-7_q3");
        run8(8'h80, 8'h80, 16'h4000, "m-128_q-128");
        run8(8'h7F, 8'h80, 16'hC080, "m127_q-128");
        run8(8'h00, 8'hFF, 16'h0000, "m0_q-1");
        chk16("m0_q-1_n_sub", n_sub, 16'd1);
        chk16("m0_q-1_n_add", n_add, 16'd0);
        run8(8'hFF, 8'h00, 16'h0000, "m-1_q0");
        chk16("m-1_q0_n_sub", n_sub, 16'd0);
        chk16("m-1_q0_n_add", n_add, 16'd0);

        // start pulsed mid-calculation with new operands is ignored
        start8 = 1'b1; mc8 = 8'd3; mq8 = 8'd5;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start8 = 1'b1; mc8 = 8'd9; mq8 = 8'd9;
        @(posedge clk); #1;
        start8 = 1'b0;
        chk1("midstart_busy", busy8, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk1("midstart_valid_early", valid8, 1'b0);
        @(posedge clk); #1;
        chk1("midstart_valid", valid8, 1'b1);
        chk16("midstart_product", product8, 16'h000F);

        // Asynchronous reset at CALC step 4 takes effect before the next edge
        start8 = 1'b1; mc8 = 8'd5; mq8 = 8'd5;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk1("abort_ready", ready8, 1'b1);
        chk1("abort_busy", busy8, 1'b0);
        chk1("abort_valid", valid8, 1'b0);
        chk16("abort_product", product8, 16'h0000);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk1("abort_idle_valid", valid8, 1'b0);
        run8(8'd10, 8'hF6, 16'hFF9C, "m10_q-10");

        // Back-to-back with start held high
        start8 = 1'b1; mc8 = 8'd6; mq8 = 8'd7;
        @(posedge clk); #1;
        mc8 = 8'hFD; mq8 = 8'd4;
        repeat (7) @(posedge clk);
        #1;
        chk1("b2b_valid_before", valid8, 1'b0);
        @(posedge clk); #1;
        chk1("b2b_first_valid", valid8, 1'b1);
        chk16("b2b_first_product", product8, 16'h002A);
        @(posedge clk); #1;
        start8 = 1'b0;
        chk1("b2b_valid_dropped", valid8, 1'b0);
        chk1("b2b_second_busy", busy8, 1'b1);
        repeat (7) @(posedge clk);
        #1;
        chk1("b2b_second_valid_early", valid8, 1'b0);
        @(posedge clk); #1;
        chk1("b2b_second_valid", valid8, 1'b1);
        chk16("b2b_second_product", product8, 16'hFFF4);

        chk1("op_exclusive", op_both, 1'b0);

        // 4-bit instance: directed corner then exhaustive sweep
        run4(4'h8, 4'd7, 8'hC8, "w4_m-8_q7");
        for (int a = -8; a < 8; a++) begin
            for (int b = -8; b < 8; b++) begin
                e4 = 8'(a * b);
                run4(4'(a), 4'(b), e4, "w4_sweep");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
